bcd_key_entry: RTL and testbench
================================

Name: bcd_key_entry

Overview:
- Sequential, parametrised successor to the one-hot decimal-to-BCD encoder.
- Accepts one-hot decimal key strobes and encodes each into a BCD digit.
- Shifts each digit into a DIGITS-wide signed BCD operand register, with sign toggle, clear, enter, and a valid/ready output handshake.
- Feeds operand A/B of the signed BCD adder/subtractor.

Parameters:
- DIGITS, 3, number of BCD digits held (≥1).
- CW, $clog2(DIGITS+1), width of the digit-count output (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  entry enable; gates key_vld, key_i, sign_key, clr, enter
- key_i  input  10  one-hot decimal key; bit n = digit n
- key_vld  input  1  single-cycle key strobe
- sign_key  input  1  single-cycle strobe; toggles sign
- clr  input  1  clears the operand being entered
- enter  input  1  commits the operand
- out_rdy  input  1  consumer ready
- bcd_o  output  4*DIGITS  operand digits; [3:0] = least significant digit
- sign_o  output  1  1 = negative
- cnt_o  output  CW  number of digits entered
- full_o  output  1  cnt_o == DIGITS
- err_o  output  1  sticky invalid-key flag
- out_vld  output  1  operand committed and stable

Behaviour:
- Reset (async, immediate): bcd_o=0, sign_o=0, cnt_o=0, full_o=0, err_o=0, out_vld=0, state=ENTRY.
- States:
  - ENTRY: accepts input.
  - HOLD: out_vld=1; bcd_o, sign_o, cnt_o and err_o are frozen.
- Encoding: key_i with exactly one bit n set gives the 4-bit value n (0..9). Zero bits set or more than one bit set is invalid.
- ENTRY, en=1. Per cycle, apply in this priority order:
  1. clr: bcd_o=0, sign_o=0, cnt_o=0, err_o=0. All other inputs in that cycle are ignored.
  2. key_vld with an invalid code: err_o<=1; digits unchanged.
  3. key_vld with a valid code and cnt_o<DIGITS: bcd_o <= {bcd_o[4*DIGITS-5:0], code}; cnt_o += 1. Leading zeros count as digits.
  4. key_vld with a valid code and cnt_o==DIGITS: key dropped; no state change; err_o unaffected.
  5. sign_key (independent of 2–4): sign_o <= ~sign_o.
  6. enter: state <= HOLD and out_vld <= 1 next cycle. The committed value includes any key or sign change from the same cycle. If the committed magnitude is all zero, sign_o is forced to 0 (no negative zero).
- Latency: a key is visible on bcd_o and cnt_o one cycle after key_vld. out_vld rises one cycle after enter.
- HOLD:
  - key_vld, sign_key, clr and enter are ignored regardless of en.
  - out_vld stays high until out_vld & out_rdy. On that cycle the handshake completes.
  - Next cycle: out_vld=0, bcd_o=0, sign_o=0, cnt_o=0, err_o=0, state=ENTRY.
  - out_rdy high while in ENTRY has no effect.
- en=0 in ENTRY: all entry inputs are ignored; state is held.
- en does not gate the HOLD handshake.
- full_o is combinational from cnt_o.
- rst asserted mid-entry or mid-HOLD: immediate return to reset values; a pending operand is discarded.

Test Plan:
1. Reset then keys 7, 0, 3 (key_i = 0x080, 0x001, 0x008) → bcd_o=0x703, cnt_o=3, full_o=1. A fourth key 5 → bcd_o unchanged, err_o=0.
2. Keys 4, 2; sign_key; enter; out_rdy held low 3 cycles → out_vld=1 and bcd_o=0x042, sign_o=1 stable throughout. Raise out_rdy → next cycle out_vld=0, bcd_o=0, cnt_o=0.
3. key_i=0x003 or 0x000 with key_vld → err_o=1, digits unchanged. clr → err_o=0, bcd_o=0.
4. Same-cycle key 9 + enter → committed bcd_o=0x009. Same-cycle clr + key 5 → bcd_o=0, cnt_o=0.
5. sign_key then enter with no digits → out_vld=1, bcd_o=0, sign_o=0 (negative zero suppressed).
6. rst pulse mid-HOLD with out_vld=1 → out_vld drops asynchronously; all outputs 0. DIGITS=4 build: keys 1, 2, 3, 4 → bcd_o=0x1234.

Source files
------------

// File: rtl/bcd_key_entry_if.sv
// ---------------------------------------------------------------------------
// bcd_key_entry_if
//   Bundles the key-entry controls and the committed-operand handshake of
//   bcd_key_entry.
//   master : the keypad/consumer side (drives keys, controls, out_rdy)
//   slave  : the entry block (drives operand, status, out_vld)
//   Signals:
//     en, key_i[9:0], key_vld, sign_key, clr, enter, out_rdy  -> entry block
//     bcd_o[4*DIGITS-1:0], sign_o, cnt_o[CW-1:0], full_o,
//     err_o, out_vld                                          <- entry block
// ---------------------------------------------------------------------------
interface bcd_key_entry_if #(
    parameter int DIGITS = 3
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  en;
    logic [9:0]            key_i;
    logic                  key_vld;
    logic                  sign_key;
    logic                  clr;
    logic                  enter;
    logic                  out_rdy;
    logic [4*DIGITS-1:0]   bcd_o;
    logic                  sign_o;
    logic [CW-1:0]         cnt_o;
    logic                  full_o;
    logic                  err_o;
    logic                  out_vld;

    modport master (
        output en, key_i, key_vld, sign_key, clr, enter, out_rdy,
        input  bcd_o, sign_o, cnt_o, full_o, err_o, out_vld
    );

    modport slave (
        input  en, key_i, key_vld, sign_key, clr, enter, out_rdy,
        output bcd_o, sign_o, cnt_o, full_o, err_o, out_vld
    );
endinterface

// File: rtl/bcd_key_entry.sv
// ---------------------------------------------------------------------------
// bcd_key_entry
//   Collects one-hot decimal key strobes into a DIGITS-wide signed BCD
//   operand (sign/magnitude), then presents the committed operand with a
//   valid/ready handshake for the BCD adder/subtractor.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - bcd_key_entry_if.slave (key inputs, controls, operand, status)
//   The interface instance must be built with the same DIGITS value.
// ---------------------------------------------------------------------------
module bcd_key_entry #(
    parameter int DIGITS = 3,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    bcd_key_entry_if.slave     bus
);

    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                state_q, state_n;
    logic [4*DIGITS-1:0]   bcd_q,   bcd_n;
    logic                  sign_q,  sign_n;
    logic [CW-1:0]         cnt_q,   cnt_n;
    logic                  err_q,   err_n;
    logic                  vld_q,   vld_n;

    // Appending the new digit below the full register and keeping the low
    // part works for every DIGITS, including 1 where there is nothing to shift.
    logic [4*DIGITS+3:0]   shifted;

    // A key is valid only when exactly one of the ten lines is set.
    function automatic logic key_valid(input logic [9:0] k);
        return $onehot(k);
    endfunction

    function automatic logic [3:0] key_code(input logic [9:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int n = 0; n < 10; n++) begin
            if (k[n]) begin
                c = 4'(n);
            end
        end
        return c;
    endfunction

    assign shifted = {bcd_q, key_code(bus.key_i)};

    always_comb begin
        state_n = state_q;
        bcd_n   = bcd_q;
        sign_n  = sign_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        vld_n   = vld_q;

        case (state_q)
            ENTRY: begin
                if (bus.en) begin
                    if (bus.clr) begin
                        // clr wins over everything else presented this cycle
                        bcd_n  = '0;
                        sign_n = 1'b0;
                        cnt_n  = '0;
                        err_n  = 1'b0;
                    end else begin
                        if (bus.key_vld) begin
                            if (!key_valid(bus.key_i)) begin
                                err_n = 1'b1;
                            end else if (cnt_q < CW'(DIGITS)) begin
                                bcd_n = shifted[4*DIGITS-1:0];
                                cnt_n = cnt_q + CW'(1);
                            end
                            // valid key on a full register is silently dropped
                        end
                        if (bus.sign_key) begin
                            sign_n = ~sign_q;
                        end
                        if (bus.enter) begin
                            state_n = HOLD;
                            vld_n   = 1'b1;
                            // commit uses this cycle's digit; no negative zero
                            if (bcd_n == '0) begin
                                sign_n = 1'b0;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (vld_q && bus.out_rdy) begin
                    state_n = ENTRY;
                    vld_n   = 1'b0;
                    bcd_n   = '0;
                    sign_n  = 1'b0;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                end
            end
            default: begin
                state_n = ENTRY;
                vld_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTRY;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            bcd_q   <= bcd_n;
            sign_q  <= sign_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            vld_q   <= vld_n;
        end
    end

    assign bus.bcd_o   = bcd_q;
    assign bus.sign_o  = sign_q;
    assign bus.cnt_o   = cnt_q;
    assign bus.full_o  = (cnt_q == CW'(DIGITS));
    assign bus.err_o   = err_q;
    assign bus.out_vld = vld_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// ---------------------------------------------------------------------------
// tb_bcd_key_entry
//   Bench for bcd_key_entry: a DIGITS=3 instance driven cycle by cycle with a
//   behavioural entry model, committed operands queued at enter and checked
//   at the handshake, plus a DIGITS=4 instance for the wider build.
// ---------------------------------------------------------------------------
module tb_bcd_key_entry;

    logic clk;
    logic rst;

    bcd_key_entry_if #(.DIGITS(3)) bus3 ();
    bcd_key_entry_if #(.DIGITS(4)) bus4 ();

    bcd_key_entry #(.DIGITS(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    bcd_key_entry #(.DIGITS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [11:0] bcd;
        logic        sign;
        int          cnt;
    } op_t;

    op_t sb[$];

    // behavioural model of the DIGITS=3 entry register
    logic [11:0] m_bcd;
    logic        m_sign;
    int          m_cnt;
    logic        m_err;
    logic        m_hold;

    function automatic logic [9:0] oh(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    task automatic model_clear();
        m_bcd  = 12'h000;
        m_sign = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bcd"},  32'(bus3.bcd_o),   32'(m_bcd));
        chk({tag, ".sign"}, 32'(bus3.sign_o),  32'(m_sign));
        chk({tag, ".cnt"},  32'(bus3.cnt_o),   32'(m_cnt));
        chk({tag, ".full"}, 32'(bus3.full_o),  32'(m_cnt == 3));
        chk({tag, ".err"},  32'(bus3.err_o),   32'(m_err));
        chk({tag, ".vld"},  32'(bus3.out_vld), 32'(m_hold));
    endtask

    // One clock of stimulus on the DIGITS=3 instance; called at posedge+1.
    task automatic step(input string tag, input logic e, input logic kv,
                        input logic [9:0] key, input logic sk, input logic cl,
                        input logic ent, input logic rdy);
        logic [3:0] code;
        op_t        op;
        bus3.en       = e;
        bus3.key_vld  = kv;
        bus3.key_i    = key;
        bus3.sign_key = sk;
        bus3.clr      = cl;
        bus3.enter    = ent;
        bus3.out_rdy  = rdy;

        code = 4'd0;
        for (int n = 0; n < 10; n++) begin
            if (key[n]) code = 4'(n);
        end
        if (m_hold) begin
            if (rdy) begin
                m_hold = 1'b0;
                model_clear();
            end
        end else if (e) begin
            if (cl) begin
                model_clear();
            end else begin
                if (kv) begin
                    if ($countones(key) != 1) m_err = 1'b1;
                    else if (m_cnt < 3) begin
                        m_bcd = {m_bcd[7:0], code};
                        m_cnt++;
                    end
                end
                if (sk) m_sign = ~m_sign;
                if (ent) begin
                    m_hold = 1'b1;
                    if (m_bcd == 12'h000) m_sign = 1'b0;
                    op.bcd  = m_bcd;
                    op.sign = m_sign;
                    op.cnt  = m_cnt;
                    sb.push_back(op);
                end
            end
        end

        @(posedge clk);
        #1;
        bus3.key_vld  = 1'b0;
        bus3.key_i    = 10'd0;
        bus3.sign_key = 1'b0;
        bus3.clr      = 1'b0;
        bus3.enter    = 1'b0;
        bus3.out_rdy  = 1'b0;
        check_all(tag);
    endtask

    // Committed operands are checked when the handshake completes.
    always @(negedge clk) begin
        if (!rst && bus3.out_vld && bus3.out_rdy) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                op_t e;
                e = sb.pop_front();
                chk("hs.bcd",  32'(bus3.bcd_o),  32'(e.bcd));
                chk("hs.sign", 32'(bus3.sign_o), 32'(e.sign));
                chk("hs.cnt",  32'(bus3.cnt_o),  32'(e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus3.en = 1'b0; bus3.key_i = 10'd0; bus3.key_vld = 1'b0; bus3.sign_key = 1'b0;
        bus3.clr = 1'b0; bus3.enter = 1'b0; bus3.out_rdy = 1'b0;
        bus4.en = 1'b0; bus4.key_i = 10'd0; bus4.key_vld = 1'b0; bus4.sign_key = 1'b0;
        bus4.clr = 1'b0; bus4.enter = 1'b0; bus4.out_rdy = 1'b0;
        model_clear();
        m_hold = 1'b0;

        #2;
        check_all("reset");
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // keys 7, 0, 3 then a dropped fourth key
        step("k7", 1, 1, oh(7), 0, 0, 0, 0);
        step("k0", 1, 1, oh(0), 0, 0, 0, 0);
        step("k3", 1, 1, oh(3), 0, 0, 0, 0);
        chk("t1.bcd",  32'(bus3.bcd_o),  32'h703);
        chk("t1.cnt",  32'(bus3.cnt_o),  32'd3);
        chk("t1.full", 32'(bus3.full_o), 32'd1);
        step("k5drop", 1, 1, oh(5), 0, 0, 0, 0);
        chk("t1.drop.bcd", 32'(bus3.bcd_o), 32'h703);
        chk("t1.drop.err", 32'(bus3.err_o), 32'd0);
        step("clr1", 1, 0, 10'd0, 0, 1, 0, 0);

        // en low: everything ignored
        step("en0", 0, 1, oh(6), 1, 0, 1, 0);

        // 4, 2, sign, enter, stall three cycles, then accept
        step("k4", 1, 1, oh(4), 0, 0, 0, 0);
        step("k2", 1, 1, oh(2), 0, 0, 0, 0);
        step("sgn", 1, 0, 10'd0, 1, 0, 0, 0);
        step("ent", 1, 0, 10'd0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 0, 10'd0, 0, 0, 0, 0);
            chk("t2.vld",  32'(bus3.out_vld), 32'd1);
            chk("t2.bcd",  32'(bus3.bcd_o),   32'h042);
            chk("t2.sign", 32'(bus3.sign_o),  32'd1);
        end
        // inputs in HOLD are ignored
        step("hold_ign", 1, 1, oh(9), 1, 1, 1, 0);
        step("accept", 1, 0, 10'd0, 0, 0, 0, 1);
        chk("t2.done.vld", 32'(bus3.out_vld), 32'd0);
        chk("t2.done.bcd", 32'(bus3.bcd_o),   32'h000);
        chk("t2.done.cnt", 32'(bus3.cnt_o),   32'd0);
        // out_rdy in ENTRY does nothing
        step("rdy_entry", 1, 0, 10'd0, 0, 0, 0, 1);

        // invalid keys set err, clr clears it
        step("k1", 1, 1, oh(1), 0, 0, 0, 0);
        step("bad3", 1, 1, 10'h003, 0, 0, 0, 0);
        chk("t3.err", 32'(bus3.err_o), 32'd1);
        chk("t3.bcd", 32'(bus3.bcd_o), 32'h001);
        step("bad0", 1, 1, 10'h000, 0, 0, 0, 0);
        chk("t3.err0", 32'(bus3.err_o), 32'd1);
        step("clr3", 1, 0, 10'd0, 0, 1, 0, 0);
        chk("t3.clr.err", 32'(bus3.err_o), 32'd0);
        chk("t3.clr.bcd", 32'(bus3.bcd_o), 32'h000);

        // key 9 together with enter
        step("k9ent", 1, 1, oh(9), 0, 0, 1, 0);
        chk("t4.bcd", 32'(bus3.bcd_o),   32'h009);
        chk("t4.vld", 32'(bus3.out_vld), 32'd1);
        step("accept4", 1, 0, 10'd0, 0, 0, 0, 1);
        // clr beats a same-cycle key
        step("k2b", 1, 1, oh(2), 0, 0, 0, 0);
        step("clrk5", 1, 1, oh(5), 0, 1, 0, 0);
        chk("t4.clr.bcd", 32'(bus3.bcd_o), 32'h000);
        chk("t4.clr.cnt", 32'(bus3.cnt_o), 32'd0);

        // negative zero suppressed
        step("sgn5", 1, 0, 10'd0, 1, 0, 0, 0);
        step("ent5", 1, 0, 10'd0, 0, 0, 1, 0);
        chk("t5.vld",  32'(bus3.out_vld), 32'd1);
        chk("t5.bcd",  32'(bus3.bcd_o),   32'h000);
        chk("t5.sign", 32'(bus3.sign_o),  32'd0);
        step("accept5", 1, 0, 10'd0, 0, 0, 0, 1);

        // asynchronous reset while holding an operand
        step("k8", 1, 1, oh(8), 0, 0, 0, 0);
        step("ent6", 1, 1, oh(3), 1, 0, 1, 0);
        chk("t6.vld_pre", 32'(bus3.out_vld), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("t6.rst.vld",  32'(bus3.out_vld), 32'd0);
        chk("t6.rst.bcd",  32'(bus3.bcd_o),   32'h000);
        chk("t6.rst.sign", 32'(bus3.sign_o),  32'd0);
        chk("t6.rst.cnt",  32'(bus3.cnt_o),   32'd0);
        #2 rst = 1'b0;
        sb.delete();
        model_clear();
        m_hold = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst");

        // DIGITS=4 build: 1, 2, 3, 4
        bus4.en = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            bus4.key_i   = oh(d);
            bus4.key_vld = 1'b1;
            @(posedge clk);
            #1;
            bus4.key_vld = 1'b0;
            bus4.key_i   = 10'd0;
        end
        chk("d4.bcd",  32'(bus4.bcd_o),  32'h1234);
        chk("d4.cnt",  32'(bus4.cnt_o),  32'd4);
        chk("d4.full", 32'(bus4.full_o), 32'd1);

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
